// File: rtl/nibble_word_assembler.sv
// nibble_word_assembler: pops nibbles from the channel queue head and packs NIBBLES of them into a word
// offered on a valid/ready port; flush drops a partial word, a presented word is only retired by ready.
module nibble_word_assembler #(
    parameter int NIBBLES = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         q_empty,
    input  logic [3:0]   q_data,
    input  logic         q_push_req,
    output logic         q_pop,
    output logic         word_valid,
    output logic [W-1:0] word_data,
    input  logic         word_ready,
    input  logic         flush,
    output logic [7:0]   word_count
);
    typedef enum logic {COLLECT, HOLD} state_t;
    state_t state, state_next;
    logic [2:0] nib_cnt, slot;
    logic [W-1:0] sr, sr_ins;
    logic last, accept;
    always_comb begin
        sr_ins = sr;
        slot = MSB_FIRST ? 3'(NIBBLES - 1) - nib_cnt : nib_cnt;
        for (int i = 0; i < NIBBLES; i++)
            if (slot == 3'(i)) sr_ins[4*i +: 4] = q_data;
        last = nib_cnt == 3'(NIBBLES - 1);
        q_pop = 1'b0;
        accept = 1'b0;
        state_next = state;
        if (state == COLLECT) begin
            q_pop = !q_empty && !q_push_req && !flush && !reset;
            if (q_pop && last) state_next = HOLD;
        end else if (word_ready) begin
            accept = 1'b1;
            state_next = COLLECT;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
            nib_cnt <= '0;
            sr <= '0;
            word_valid <= 1'b0;
            word_data <= '0;
            word_count <= '0;
        end else begin
            state <= state_next;
            if (state == COLLECT && flush) begin
                nib_cnt <= '0;
                sr <= '0;
            end else if (q_pop && last) begin
                word_data <= sr_ins;
                word_valid <= 1'b1;
                nib_cnt <= '0;
                sr <= '0;
            end else if (q_pop) begin
                sr <= sr_ins;
                nib_cnt <= nib_cnt + 3'd1;
            end
            if (accept) begin
                word_valid <= 1'b0;
                word_count <= word_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_nibble_word_assembler.sv
// tb_nibble_word_assembler: directed vectors against an MSB-first and an LSB-first instance sharing one queue model.
module tb_nibble_word_assembler;
    logic clk = 1'b0;
    logic reset = 1'b1, q_push_req = 1'b0, word_ready = 1'b1, flush = 1'b0;
    logic q_empty, q_pop, q_pop2, word_valid, word_valid2;
    logic [3:0] q_data;
    logic [15:0] word_data, word_data2;
    logic [7:0] word_count, word_count2;
    logic [3:0] mem [0:2047];
    int rd = 0, wr = 0;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    assign q_empty = rd == wr;
    assign q_data = mem[rd[10:0]];

    always @(posedge clk) if (q_pop) rd <= rd + 1;

    nibble_word_assembler #(.NIBBLES(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .q_empty(q_empty), .q_data(q_data), .q_push_req(q_push_req),
        .q_pop(q_pop), .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
        .flush(flush), .word_count(word_count));

    nibble_word_assembler #(.NIBBLES(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .q_empty(q_empty), .q_data(q_data), .q_push_req(q_push_req),
        .q_pop(q_pop2), .word_valid(word_valid2), .word_data(word_data2), .word_ready(word_ready),
        .flush(flush), .word_count(word_count2));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] n);
        mem[wr[10:0]] = n;
        wr++;
    endtask

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic pops(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, {15'd0, q_pop}, 16'd1);
            cyc();
        end
    endtask

    initial begin
        int n;
        @(negedge clk);
        #1;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        #1;
        chk("reset_pop0", {15'd0, q_pop}, 16'd0);
        cyc();
        chk("reset_pop1", {15'd0, q_pop}, 16'd0);
        cyc();
        chk("reset_valid", {15'd0, word_valid}, 16'd0);
        chk("reset_data", word_data, 16'h0000);
        chk("reset_count", {8'd0, word_count}, 16'd0);
        reset = 1'b0;
        #1;
        pops("basic_pop", 4);
        chk("basic_valid", {15'd0, word_valid}, 16'd1);
        chk("basic_data", word_data, 16'h1234);
        chk("basic_data_lsb", word_data2, 16'h4321);
        chk("basic_hold_pop", {15'd0, q_pop}, 16'd0);
        cyc();
        chk("basic_valid_drop", {15'd0, word_valid}, 16'd0);
        chk("basic_count", {8'd0, word_count}, 16'd1);

        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        #1;
        pops("cont_pop_first", 1);
        q_push_req = 1'b1;
        #1;
        chk("cont_pop_suppressed", {15'd0, q_pop}, 16'd0);
        cyc();
        q_push_req = 1'b0;
        #1;
        pops("cont_pop_resume", 3);
        chk("cont_data", word_data, 16'h1234);
        chk("cont_valid", {15'd0, word_valid}, 16'd1);
        cyc();
        chk("cont_count", {8'd0, word_count}, 16'd2);

        word_ready = 1'b0;
        push(4'hA); push(4'hB); push(4'hC); push(4'hD);
        push(4'hE); push(4'hF); push(4'h0); push(4'h1);
        #1;
        pops("bp_pop", 4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {15'd0, word_valid}, 16'd1);
            chk("bp_data", word_data, 16'hABCD);
            chk("bp_pop_held", {15'd0, q_pop}, 16'd0);
            cyc();
        end
        word_ready = 1'b1;
        #1;
        chk("bp_handshake_pop", {15'd0, q_pop}, 16'd0);
        cyc();
        chk("bp_valid_drop", {15'd0, word_valid}, 16'd0);
        chk("bp_count", {8'd0, word_count}, 16'd3);
        pops("bp_resume_pop", 4);
        chk("bp_next_data", word_data, 16'hEF01);
        cyc();
        chk("bp_next_count", {8'd0, word_count}, 16'd4);

        push(4'h5); push(4'h6); push(4'h7); push(4'h8); push(4'h9); push(4'hA);
        #1;
        pops("flush_pre_pop", 2);
        flush = 1'b1;
        #1;
        chk("flush_pop", {15'd0, q_pop}, 16'd0);
        cyc();
        flush = 1'b0;
        #1;
        pops("flush_post_pop", 4);
        chk("flush_data", word_data, 16'h789A);
        chk("flush_data_lsb", word_data2, 16'hA987);
        cyc();
        chk("flush_count", {8'd0, word_count}, 16'd5);

        for (int i = 0; i < 1004; i++) push(4'(i));
        n = 0;
        while (word_count !== 8'd0 && n < 3000) begin
            cyc();
            n++;
        end
        chk("wrap_count", {8'd0, word_count}, 16'd0);
        chk("wrap_valid", {15'd0, word_valid}, 16'd0);
        chk("wrap_drained", {15'd0, q_empty}, 16'd1);

        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        #1;
        pops("lsb_pop", 4);
        chk("lsb_data", word_data2, 16'h4321);
        chk("lsb_msb_data", word_data, 16'h1234);
        cyc();
        chk("lsb_count", {8'd0, word_count2}, 16'd1);

        push(4'h1); push(4'h2);
        #1;
        pops("midreset_pop", 2);
        reset = 1'b1;
        #1;
        chk("midreset_pop_gated", {15'd0, q_pop}, 16'd0);
        cyc();
        reset = 1'b0;
        chk("midreset_valid", {15'd0, word_valid}, 16'd0);
        chk("midreset_count", {8'd0, word_count}, 16'd0);
        push(4'h3); push(4'h4); push(4'h5); push(4'h6);
        #1;
        pops("midreset_pop_after", 4);
        chk("midreset_data", word_data, 16'h3456);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
